crossbar_mlc_engine: RTL
========================

// Module: crossbar_mlc_engine
// PURPOSE
//  Parametrised MLC ReRAM crossbar engine: a ROWSxCOLS array of WBITS-bit conductance levels.
//  Programming emulates incremental step-pulse programming: one level step per pulse toward the target.
//  Inference is a handshaked, row-serial VMM (LANES rows per cycle), with results held until accepted.
//  Sits between the spike encoder (upstream) and the LIF neuron array (downstream).
// PARAMETERS
//  ROWS       32  crossbar rows (spike inputs)
//  COLS       10  crossbar columns (output sums)
//  WBITS      4   bits per cell (2**WBITS levels)
//  LANES      4   rows accumulated per cycle; ROWS % LANES == 0 (elaboration $error otherwise)
//  ACC_W      16  output sum width
//  PULSE_CYC  2   cycles per programming pulse, >=1
// PORTS
//  clk          in   1                   clock
//  rst_n        in   1                   asynchronous, active-low reset
//  prog_valid   in   1                   program request
//  prog_ready   out  1                   engine can accept a program request
//  prog_row     in   $clog2(ROWS)        target row
//  prog_col     in   $clog2(COLS)        target column
//  prog_level   in   WBITS               target level
//  prog_done    out  1                   1-cycle pulse: program finished
//  prog_err     out  1                   1-cycle pulse: address out of range, no write
//  prog_pulses  out  WBITS+1             pulse count of the last program; valid with prog_done
//  in_valid     in   1                   spike vector valid
//  in_ready     out  1                   spike vector accepted when in_valid & in_ready
//  in_spikes    in   ROWS                row spike vector
//  out_valid    out  1                   column sums valid
//  out_ready    in   1                   downstream accepts the sums
//  out_sum      out  [COLS][ACC_W]       column sums
//  out_sat      out  COLS                per-column saturation flag
//  busy         out  1                   state != IDLE
// BEHAVIOUR
//  Reset: every cell level 0; state IDLE; all outputs 0.
//  FSM IDLE->PROG->IDLE; IDLE->VMM->OUT->IDLE.
//  prog_ready=in_ready=1 only in IDLE. If prog_valid and in_valid are both high, programming wins.
//  PROG: request captured at acceptance.
//   - Row >= ROWS or col >= COLS: prog_err pulses next cycle, no write, back to IDLE.
//   - Otherwise every PULSE_CYC cycles the cell moves +/-1 level toward the target.
//   - When level==target: prog_done pulses and prog_pulses = |target - start|.
//   - Target equal to current level: prog_done on the cycle after acceptance, prog_pulses=0.
//   - prog_done cycle = acceptance + |diff|*PULSE_CYC + 1.
//  VMM: spikes registered at acceptance; sums cleared.
//   - Each cycle adds the level of every spiking row in LANES rows to each column.
//   - Zero-extend levels to ACC_W.
//   - ROWS/LANES cycles, then out_valid=1 on the following cycle.
//  OUT: out_sum/out_sat stable while out_valid & !out_ready.
//   - Handshake on out_valid & out_ready, then IDLE; one bubble before the next acceptance.
//  Inputs are ignored outside handshakes; cells are never written during VMM/OUT.
//  Reset mid-operation: immediate abort; all cells return to 0, outputs to 0.
// CONFIGURATION
//  XBAR_ACC_SAT_EN defined:
//   - Accumulation clamps at 2**ACC_W-1.
//   - out_sat[j]=1 if column j clamped during that VMM.
//  XBAR_ACC_SAT_EN undefined: modulo-2**ACC_W wrap; out_sat tied 0.
// STRUCTURE
//  Package crossbar_mlc_pkg:
//   - state_e enum (IDLE,PROG,VMM,OUT)
//   - level_t typedef, parametrised widths helper
//  Sub-module xbar_lane_accumulator: adds one LANES-row slice to one column; saturating per macro.
//   - Instantiated COLS times.
// TESTING
//  1. After reset, a full VMM with all spikes high -> out_sum all 0; out_sat 0.
//  2. Program (3,2) to 9 with PULSE_CYC=2 -> prog_done 19 cycles after accept, prog_pulses=9.
//     Then program it to 4 -> prog_pulses=5, level 4.
//  3. Program all cells to 15, then all 32 spikes -> out_sum=480 per column.
//     out_valid 9 cycles after accept (LANES=4).
//  4. Backpressure: out_ready low 5 cycles -> out_sum stable, in_ready=0; then accept, IDLE.
//  5. ACC_W=8, all levels 15 -> with macro out_sum=255, out_sat all 1; without, 224, out_sat 0.
//  6. prog_row=40 -> prog_err pulse, no cell changed. Assert rst_n mid-PROG -> all levels 0.

Source files
------------

// File: rtl/crossbar_mlc_pkg.sv
// Shared types and width helpers for the MLC ReRAM crossbar engine.
package crossbar_mlc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        VMM  = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam int unsigned DEF_WBITS = 4;

    typedef logic [DEF_WBITS-1:0] level_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_lane_accumulator.sv
// Adds the spiking levels of one LANES-row slice to a single column sum.
// XBAR_ACC_SAT_EN selects clamping at 2**ACC_W-1; otherwise the sum wraps.
module xbar_lane_accumulator
    import crossbar_mlc_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned WBITS = 4,
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0]       acc_i,
    input  logic [LANES*WBITS-1:0] lvl_i,
    input  logic [LANES-1:0]       spk_i,
    output logic [ACC_W-1:0]       sum_c,
    output logic                   sat_c
);

`ifdef XBAR_ACC_SAT_EN
    localparam int unsigned SUM_W = ACC_W + WBITS + idx_w(LANES);
`else
    localparam int unsigned SUM_W = ACC_W;
`endif

    logic [SUM_W-1:0] total;

    always_comb begin
        total = SUM_W'(acc_i);
        for (int l = 0; l < int'(LANES); l++) begin
            if (spk_i[l]) begin
                total = total + SUM_W'(lvl_i[l*WBITS +: WBITS]);
            end
        end
    end

`ifdef XBAR_ACC_SAT_EN
    always_comb begin
        sat_c = |total[SUM_W-1:ACC_W];
        sum_c = sat_c ? {ACC_W{1'b1}} : total[ACC_W-1:0];
    end
`else
    assign sum_c = total;
    assign sat_c = 1'b0;
`endif

endmodule

// File: rtl/crossbar_mlc_engine.sv
// MLC ReRAM crossbar: step-pulse cell programming and row-serial handshaked VMM.
// Optional build macro XBAR_ACC_SAT_EN enables saturating column sums.
module crossbar_mlc_engine
    import crossbar_mlc_pkg::*;
#(
    parameter int unsigned ROWS      = 32,
    parameter int unsigned COLS      = 10,
    parameter int unsigned WBITS     = 4,
    parameter int unsigned LANES     = 4,
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned PULSE_CYC = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         prog_valid,
    output logic                         prog_ready,
    input  logic [idx_w(ROWS)-1:0]       prog_row,
    input  logic [idx_w(COLS)-1:0]       prog_col,
    input  logic [WBITS-1:0]             prog_level,
    output logic                         prog_done,
    output logic                         prog_err,
    output logic [WBITS:0]               prog_pulses,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ROWS-1:0]              in_spikes,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COLS-1:0][ACC_W-1:0]   out_sum,
    output logic [COLS-1:0]              out_sat,
    output logic                         busy
);

    localparam int unsigned RW     = idx_w(ROWS);
    localparam int unsigned CW     = idx_w(COLS);
    localparam int unsigned NSLICE = ROWS / LANES;
    localparam int unsigned SW     = idx_w(NSLICE);
    localparam int unsigned PW     = idx_w(PULSE_CYC);
    localparam int unsigned DW     = WBITS + 1;

    if (ROWS % LANES != 0) begin : g_bad_lanes
        $error("crossbar_mlc_engine: ROWS must be a multiple of LANES");
    end
    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("crossbar_mlc_engine: PULSE_CYC must be at least 1");
    end

    state_e                      state_q, state_d;
    logic [WBITS-1:0]            cells_q [ROWS][COLS];
    logic [WBITS-1:0]            cells_d [ROWS][COLS];
    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               col_q, col_d;
    logic                        up_q, up_d;
    logic [DW-1:0]               rem_q, rem_d, npulse_q, npulse_d;
    logic [PW-1:0]               pc_q, pc_d;
    logic [SW-1:0]               slice_q, slice_d;
    logic [ROWS-1:0]             spikes_q, spikes_d;
    logic [COLS-1:0][ACC_W-1:0]  sum_q, sum_d, acc_sum;
    logic [COLS-1:0]             sat_q, sat_d, acc_sat;
    logic                        out_valid_q, out_valid_d;
    logic                        prog_done_q, prog_done_d, prog_err_q, prog_err_d;
    logic [DW-1:0]               prog_pulses_q, prog_pulses_d;
    logic                        prog_ready_q, in_ready_q, busy_q;
    logic [WBITS-1:0]            sel_lvl, cur_lvl, diff;

    // One accumulator per column, fed by the current LANES-row slice.
    for (genvar j = 0; j < int'(COLS); j++) begin : g_col
        logic [LANES*WBITS-1:0] lvl;
        logic [LANES-1:0]       spk;
        always_comb begin
            logic [RW-1:0] r;
            lvl = '0;
            spk = '0;
            for (int l = 0; l < int'(LANES); l++) begin
                r = RW'(32'(slice_q) * LANES + 32'(l));
                lvl[l*WBITS +: WBITS] = cells_q[r][j];
                spk[l]                = spikes_q[r];
            end
        end
        xbar_lane_accumulator #(
            .LANES (LANES),
            .WBITS (WBITS),
            .ACC_W (ACC_W)
        ) u_acc (
            .acc_i (sum_q[j]),
            .lvl_i (lvl),
            .spk_i (spk),
            .sum_c (acc_sum[j]),
            .sat_c (acc_sat[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        cells_d       = cells_q;
        row_d         = row_q;
        col_d         = col_q;
        up_d          = up_q;
        rem_d         = rem_q;
        npulse_d      = npulse_q;
        pc_d          = pc_q;
        slice_d       = slice_q;
        spikes_d      = spikes_q;
        sum_d         = sum_q;
        sat_d         = sat_q;
        out_valid_d   = out_valid_q;
        prog_pulses_d = prog_pulses_q;
        prog_done_d   = 1'b0;
        prog_err_d    = 1'b0;
        sel_lvl       = cells_q[prog_row][prog_col];
        cur_lvl       = cells_q[row_q][col_q];
        diff          = (prog_level > sel_lvl) ? prog_level - sel_lvl : sel_lvl - prog_level;

        unique case (state_q)
            IDLE: begin
                if (prog_valid && prog_ready_q) begin
                    if (32'(prog_row) >= ROWS || 32'(prog_col) >= COLS) begin
                        prog_err_d = 1'b1;
                    end else if (diff == '0) begin
                        prog_done_d   = 1'b1;
                        prog_pulses_d = '0;
                    end else begin
                        state_d  = PROG;
                        row_d    = prog_row;
                        col_d    = prog_col;
                        up_d     = prog_level > sel_lvl;
                        rem_d    = DW'(diff);
                        npulse_d = DW'(diff);
                        pc_d     = '0;
                    end
                end else if (in_valid && in_ready_q) begin
                    state_d  = VMM;
                    spikes_d = in_spikes;
                    sum_d    = '0;
                    sat_d    = '0;
                    slice_d  = '0;
                end
            end
            PROG: begin
                // One level step at the end of every PULSE_CYC-cycle pulse.
                if (pc_q == PW'(PULSE_CYC - 1)) begin
                    pc_d = '0;
                    cells_d[row_q][col_q] = up_q ? cur_lvl + WBITS'(1) : cur_lvl - WBITS'(1);
                    rem_d = rem_q - DW'(1);
                    if (rem_q == DW'(1)) begin
                        prog_done_d   = 1'b1;
                        prog_pulses_d = npulse_q;
                        state_d       = IDLE;
                    end
                end else begin
                    pc_d = pc_q + PW'(1);
                end
            end
            VMM: begin
                sum_d = acc_sum;
                sat_d = sat_q | acc_sat;
                if (slice_q == SW'(NSLICE - 1)) begin
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                end else begin
                    slice_d = slice_q + SW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells_q       <= '{default: '0};
            row_q         <= '0;
            col_q         <= '0;
            up_q          <= 1'b0;
            rem_q         <= '0;
            npulse_q      <= '0;
            pc_q          <= '0;
            slice_q       <= '0;
            spikes_q      <= '0;
            sum_q         <= '0;
            sat_q         <= '0;
            out_valid_q   <= 1'b0;
            prog_done_q   <= 1'b0;
            prog_err_q    <= 1'b0;
            prog_pulses_q <= '0;
            prog_ready_q  <= 1'b0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            cells_q       <= cells_d;
            row_q         <= row_d;
            col_q         <= col_d;
            up_q          <= up_d;
            rem_q         <= rem_d;
            npulse_q      <= npulse_d;
            pc_q          <= pc_d;
            slice_q       <= slice_d;
            spikes_q      <= spikes_d;
            sum_q         <= sum_d;
            sat_q         <= sat_d;
            out_valid_q   <= out_valid_d;
            prog_done_q   <= prog_done_d;
            prog_err_q    <= prog_err_d;
            prog_pulses_q <= prog_pulses_d;
            prog_ready_q  <= (state_d == IDLE);
            in_ready_q    <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
        end
    end

    assign prog_ready  = prog_ready_q;
    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign prog_done   = prog_done_q;
    assign prog_err    = prog_err_q;
    assign prog_pulses = prog_pulses_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = sum_q;
    assign out_sat     = sat_q;

endmodule
